jmb_3x3_gauss_filter: RTL

//  Downstream consumer of the 3x3 sliding-window stage. Takes the nine window

---
 rtl/jmb_3x3_gauss_filter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/jmb_3x3_gauss_filter.sv
// rtl/jmb_3x3_gauss_filter.sv - 3x3 Gaussian (1-2-1/2-4-2/1-2-1) smoother, 3-stage pipeline
// Position tracking drops windows that overlap the image border.
module jmb_3x3_gauss_filter #(
   parameter int pixel_width  = 8,
   parameter int image_width  = 512,
   parameter int image_height = 512
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   in_valid,
   input  logic                   in_sof,
   input  logic [pixel_width-1:0] w00,
   input  logic [pixel_width-1:0] w01,
   input  logic [pixel_width-1:0] w02,
   input  logic [pixel_width-1:0] w10,
   input  logic [pixel_width-1:0] w11,
   input  logic [pixel_width-1:0] w12,
   input  logic [pixel_width-1:0] w20,
   input  logic [pixel_width-1:0] w21,
   input  logic [pixel_width-1:0] w22,
   output logic [pixel_width-1:0] out_data,
   output logic                   out_valid,
   output logic                   out_eof,
   output logic                   frame_err
);

   localparam int cw  = $clog2(image_width);
   localparam int rw  = $clog2(image_height);
   localparam int rsw = pixel_width + 2;
   localparam int ssw = pixel_width + 5;

   localparam logic [cw-1:0] col_last = cw'(image_width - 1);
   localparam logic [rw-1:0] row_last = rw'(image_height - 1);
   localparam logic [cw-1:0] col_two  = cw'(2);
   localparam logic [rw-1:0] row_two  = rw'(2);

   function automatic logic [rsw-1:0] row_sum(input logic [pixel_width-1:0] a,
                                              input logic [pixel_width-1:0] b,
                                              input logic [pixel_width-1:0] c);
      return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
   endfunction

   logic [cw-1:0]          col_q, col_d;
   logic [rw-1:0]          row_q, row_d;
   logic [cw-1:0]          beat_col;
   logic [rw-1:0]          beat_row;
   logic                   interior;
   logic                   last_beat;
   logic                   frame_err_q, frame_err_d;

   logic [rsw-1:0]         r0_q, r0_d, r1_q, r1_d, r2_q, r2_d;
   logic                   v1_q, v1_d, eof1_q, eof1_d;
   logic [ssw-1:0]         s_q, s_d;
   logic                   v2_q, v2_d, eof2_q, eof2_d;
   logic [pixel_width-1:0] out_data_q, out_data_d;
   logic                   out_valid_q, out_valid_d;
   logic                   out_eof_q, out_eof_d;

   // A start-of-frame beat is forced to (0,0) regardless of where the counters were.
   always_comb begin
      beat_col  = in_sof ? '0 : col_q;
      beat_row  = in_sof ? '0 : row_q;
      interior  = in_valid && (beat_row >= row_two) && (beat_col >= col_two);
      last_beat = (beat_row == row_last) && (beat_col == col_last);
   end

   always_comb begin
      col_d       = col_q;
      row_d       = row_q;
      frame_err_d = in_valid && in_sof && ((col_q != '0) || (row_q != '0));
      if (in_valid) begin
         if (beat_col == col_last) begin
            col_d = '0;
            row_d = (beat_row == row_last) ? '0 : beat_row + rw'(1);
         end else begin
            col_d = beat_col + cw'(1);
            row_d = beat_row;
         end
      end
   end

   always_comb begin
      r0_d   = row_sum(w00, w01, w02);
      r1_d   = row_sum(w10, w11, w12);
      r2_d   = row_sum(w20, w21, w22);
      v1_d   = interior;
      eof1_d = interior && last_beat;
   end

   // The +8 bias turns the later truncation into round-half-up of sum/16.
   always_comb begin
      s_d    = {3'b000, r0_q} + {2'b00, r1_q, 1'b0} + {3'b000, r2_q} + ssw'(8);
      v2_d   = v1_q;
      eof2_d = eof1_q;
   end

   always_comb begin
      out_valid_d = v2_q;
      out_eof_d   = v2_q && eof2_q;
      out_data_d  = v2_q ? s_q[pixel_width+3:4] : out_data_q;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         col_q       <= '0;
         row_q       <= '0;
         frame_err_q <= 1'b0;
         r0_q        <= '0;
         r1_q        <= '0;
         r2_q        <= '0;
         v1_q        <= 1'b0;
         eof1_q      <= 1'b0;
         s_q         <= '0;
         v2_q        <= 1'b0;
         eof2_q      <= 1'b0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_eof_q   <= 1'b0;
      end else begin
         col_q       <= col_d;
         row_q       <= row_d;
         frame_err_q <= frame_err_d;
         r0_q        <= r0_d;
         r1_q        <= r1_d;
         r2_q        <= r2_d;
         v1_q        <= v1_d;
         eof1_q      <= eof1_d;
         s_q         <= s_d;
         v2_q        <= v2_d;
         eof2_q      <= eof2_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         out_eof_q   <= out_eof_d;
      end
   end

   // Top bit is always zero and the low nibble is the rounded-away fraction.
   logic unused_s_bits;
   assign unused_s_bits = ^{s_q[ssw-1], s_q[3:0]};

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign out_eof   = out_eof_q;
   assign frame_err = frame_err_q;

endmodule
